// File: rtl/icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_fill_ctrl
// Description : Instruction-cache miss refill controller. Accepts one miss,
//               picks a victim way, fetches the line from memory and writes
//               data, tag and status through the arrays' masked write ports.
//               One fill is outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fill_ctrl #(
    parameter int SET_BITS_WIDTH = 4,
    parameter int TAG_WIDTH      = 8,
    parameter int NUM_WAYS       = 4,
    parameter int LINE_WIDTH     = 64
) (
    input  logic                                clk,
    input  logic                                srst,
    input  logic                                i_halt,
    input  logic [SET_BITS_WIDTH-1:0]           i_miss_set,
    input  logic [TAG_WIDTH-1:0]                i_miss_tag,
    input  logic [2*NUM_WAYS-1:0]               i_miss_sa_data,
    input  logic                                i_miss_valid,
    output logic                                o_miss_ready,
    output logic [TAG_WIDTH+SET_BITS_WIDTH-1:0] o_mem_addr,
    output logic                                o_mem_req_valid,
    input  logic                                i_mem_req_ready,
    input  logic [LINE_WIDTH-1:0]               i_mem_data,
    input  logic                                i_mem_valid,
    output logic [SET_BITS_WIDTH-1:0]           o_w_ta_set_addr,
    output logic [NUM_WAYS*TAG_WIDTH-1:0]       o_w_ta_data,
    output logic [NUM_WAYS-1:0]                 o_w_ta_mask,
    output logic                                o_w_ta_valid,
    input  logic                                i_w_ta_ready,
    output logic [SET_BITS_WIDTH-1:0]           o_w_sa_set_addr,
    output logic [2*NUM_WAYS-1:0]               o_w_sa_data,
    output logic [NUM_WAYS-1:0]                 o_w_sa_mask,
    output logic                                o_w_sa_valid,
    input  logic                                i_w_sa_ready,
    output logic [SET_BITS_WIDTH-1:0]           o_w_da_set_addr,
    output logic [1:0]                          o_w_da_way,
    output logic [LINE_WIDTH-1:0]               o_w_da_data,
    output logic                                o_w_da_valid,
    input  logic                                i_w_da_ready,
    output logic                                o_fill_done,
    output logic [1:0]                          o_fill_way
);

    localparam int c_WAY_BITS = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;

    logic [SET_BITS_WIDTH-1:0] r_set;
    logic [TAG_WIDTH-1:0]      r_tag;
    logic [c_WAY_BITS-1:0]     r_victim;
    logic [NUM_WAYS-1:0]       r_mask;
    logic [c_WAY_BITS-1:0]     r_rr_ptr;
    logic [LINE_WIDTH-1:0]     r_line;
    logic [2*NUM_WAYS-1:0]     r_sa_data;
    logic                      r_ta_valid;
    logic                      r_sa_valid;
    logic                      r_da_valid;

    logic [c_WAY_BITS-1:0]     w_victim;
    logic                      w_use_rr;
    logic                      w_found_inv;
    logic                      w_found_old;
    logic [c_WAY_BITS-1:0]     w_inv_way;
    logic [c_WAY_BITS-1:0]     w_old_way;
    logic                      w_accept;
    logic                      w_ta_fire;
    logic                      w_sa_fire;
    logic                      w_da_fire;
    logic                      w_writes_done;

    // Handshakes only count while not halted; halt freezes everything.
    assign o_miss_ready  = (r_state == S_IDLE) & ~i_halt;
    assign w_accept      = i_miss_valid & o_miss_ready;
    assign w_ta_fire     = r_ta_valid & i_w_ta_ready & ~i_halt;
    assign w_sa_fire     = r_sa_valid & i_w_sa_ready & ~i_halt;
    assign w_da_fire     = r_da_valid & i_w_da_ready & ~i_halt;
    // All three ports are finished once each is either idle or completing now.
    assign w_writes_done = (~r_ta_valid | w_ta_fire) &
                           (~r_sa_valid | w_sa_fire) &
                           (~r_da_valid | w_da_fire);

    // Victim choice: lowest invalid way, else lowest non-recent way, else round-robin.
    always_comb begin
        w_found_inv = 1'b0;
        w_found_old = 1'b0;
        w_inv_way   = '0;
        w_old_way   = '0;
        w_victim    = r_rr_ptr;
        w_use_rr    = 1'b1;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!i_miss_sa_data[2*i+1]) begin
                w_found_inv = 1'b1;
                w_inv_way   = c_WAY_BITS'(i);
            end
            if (!i_miss_sa_data[2*i]) begin
                w_found_old = 1'b1;
                w_old_way   = c_WAY_BITS'(i);
            end
        end
        if (w_found_inv) begin
            w_victim = w_inv_way;
            w_use_rr = 1'b0;
        end else if (w_found_old) begin
            w_victim = w_old_way;
            w_use_rr = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; halt holds the current state.
    always_comb begin
        w_next_state = r_state;
        if (!i_halt) begin
            case (r_state)
                S_IDLE:  if (w_accept)        w_next_state = S_REQ;
                S_REQ:   if (i_mem_req_ready) w_next_state = S_WAIT;
                S_WAIT:  if (i_mem_valid)     w_next_state = S_WRITE;
                S_WRITE: if (w_writes_done)   w_next_state = S_DONE;
                S_DONE:                       w_next_state = S_IDLE;
                default:                      w_next_state = S_IDLE;
            endcase
        end
    end

    // Miss capture, line capture and per-port write valids.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_set      <= '0;
            r_tag      <= '0;
            r_victim   <= '0;
            r_mask     <= '0;
            r_rr_ptr   <= '0;
            r_line     <= '0;
            r_sa_data  <= '0;
            r_ta_valid <= 1'b0;
            r_sa_valid <= 1'b0;
            r_da_valid <= 1'b0;
        end else if (!i_halt) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_set    <= i_miss_set;
                        r_tag    <= i_miss_tag;
                        r_victim <= w_victim;
                        r_mask   <= {{(NUM_WAYS-1){1'b0}}, 1'b1} << w_victim;
                        if (w_use_rr) begin
                            r_rr_ptr <= r_rr_ptr + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_mem_valid) begin
                        r_line     <= i_mem_data;
                        r_sa_data  <= {NUM_WAYS{2'b11}};
                        r_ta_valid <= 1'b1;
                        r_sa_valid <= 1'b1;
                        r_da_valid <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (w_ta_fire) r_ta_valid <= 1'b0;
                    if (w_sa_fire) r_sa_valid <= 1'b0;
                    if (w_da_fire) r_da_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_mem_addr      = {r_tag, r_set};
    assign o_mem_req_valid = (r_state == S_REQ);

    assign o_w_ta_set_addr = r_set;
    assign o_w_ta_data     = {NUM_WAYS{r_tag}};
    assign o_w_ta_mask     = r_mask;
    assign o_w_ta_valid    = r_ta_valid;

    assign o_w_sa_set_addr = r_set;
    assign o_w_sa_data     = r_sa_data;
    assign o_w_sa_mask     = r_mask;
    assign o_w_sa_valid    = r_sa_valid;

    assign o_w_da_set_addr = r_set;
    assign o_w_da_way      = r_victim;
    assign o_w_da_data     = r_line;
    assign o_w_da_valid    = r_da_valid;

    assign o_fill_done     = (r_state == S_DONE);
    assign o_fill_way      = r_victim;

endmodule
`default_nettype wire
